chess_clock_controller: RTL and testbench
=========================================

// Module: chess_clock_controller
// PURPOSE
//  Sequences the two chess-clock countdowns (white/black) that feed the number display decoder.
//  Generates the 1 s tick, decides whose clock runs, handles move presses, increment, pause and flag-fall.
//  Outputs packed {min[3:0],sec[5:0]} times consumed directly as countdownW/countdownB by the display path.
// PARAMETERS
//  CLK_HZ     100_000_000  clk frequency; tick period = CLK_HZ cycles
//  INIT_MIN   5            initial minutes per side (0..15)
//  INIT_SEC   0            initial seconds per side (0..59)
//  INC_SEC    0            Fischer increment added to mover's clock on press (0..59)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   1-cycle pulse: IDLE->run white; PAUSED/FLAG->reload and go IDLE
//  pause       in   1   1-cycle pulse: toggles pause while running
//  press_w     in   1   1-cycle pulse, debounced upstream: white ends move
//  press_b     in   1   1-cycle pulse, debounced upstream: black ends move
//  countdownW  out  10  white time, [9:6]=minutes, [5:0]=seconds 0..59
//  countdownB  out  10  black time, same format
//  turn_w      out  1   1 = white to move / white clock selected
//  running     out  1   1 in RUN_W or RUN_B
//  flag_w      out  1   white flag fell (sticky until start)
//  flag_b      out  1   black flag fell (sticky until start)
// BEHAVIOUR
//  - Reset (async): countdownW=countdownB={INIT_MIN,INIT_SEC}; state IDLE; turn_w=1; running=0; flags=0; prescaler=0.
//  - All outputs registered; every update visible the cycle after the causing edge.
//  - States: IDLE, RUN_W, RUN_B, PAUSED (side held in turn_w), FLAG.
//  - IDLE: start -> RUN_W, prescaler cleared. press_*, pause ignored.
//  - RUN_x: prescaler counts 0..CLK_HZ-1; tick on terminal count decrements active side only.
//    Decrement: sec>0 -> sec-1; sec==0 -> min-1, sec=59. Inactive side never changes.
//  - Active press (press_w in RUN_W, press_b in RUN_B): add INC_SEC to mover (sec carry into min,
//    saturate at 15:59), switch to other RUN state, clear prescaler, toggle turn_w. Inactive press ignored.
//  - Priority same cycle in RUN_x: pause > active press > tick. Press+tick: no decrement, increment applied.
//    press_w and press_b together: only active side's press counts.
//  - Decrement reaching 0:00 -> FLAG same edge, flag_x=1, running=0; all presses/pause/ticks ignored.
//  - pause in RUN_x -> PAUSED; prescaler holds value. pause in PAUSED -> resume RUN of turn_w side.
//  - start in PAUSED or FLAG: reload both clocks to INIT, clear flags, turn_w=1, prescaler=0, -> IDLE.
//    start in RUN_x ignored.
//  - INIT of 0:00 legal: start from IDLE goes straight to FLAG with flag_w=1 on first edge.
//  - rst asserted mid-operation: immediate return to reset values regardless of state.
// STRUCTURE
//  - Package chess_clock_pkg: state enum, packed time_t {min[3:0],sec[5:0]}, T_MAX={15,59},
//    functions t_dec (borrow) and t_add_sat (carry+saturate).
//  - Sub-module tick_prescaler (clk, rst, en, clr -> tick): counter width $clog2(CLK_HZ),
//    tick 1 cycle at CLK_HZ-1, holds while en=0, clr wins over en.
//  - Top: FSM + two time_t registers + flag/turn registers; ~200 lines total.
// TESTING (bench uses CLK_HZ=10)
//  1. rst -> countdownW=countdownB=10'd320 (5:00), turn_w=1, running=0, flags=0; presses in IDLE no effect.
//  2. start, wait 10 cycles -> countdownW=10'd315 (4:59), countdownB=320, running=1.
//  3. INC_SEC=2, W at 4:59, press_w on tick cycle -> W=5:01 (10'd321), turn_w=0, B starts decrementing.
//  4. W at 1:00, one tick -> 0:59 (10'd59); W at 15:58 + INC_SEC=2 -> saturates 15:59 (10'd1019).
//  5. W at 0:01, tick -> W=0, flag_w=1, FLAG; press_*/pause no effect for 50 cycles; start -> both 320, IDLE.
//  6. pause at prescaler=6, hold 100 cycles -> no change; pause -> tick 4 cycles later; rst mid-RUN_B -> reset values.

Source files
------------

// File: rtl/chess_clock_pkg.sv
// Shared types and time arithmetic for the chess clock controller.
// A side's time is packed {min[3:0], sec[5:0]}; seconds stay within 0..59.
package chess_clock_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_W,
        S_RUN_B,
        S_PAUSED,
        S_FLAG
    } state_t;

    typedef struct packed {
        logic [3:0] min;
        logic [5:0] sec;
    } time_t;

    localparam time_t T_MAX = '{min: 4'd15, sec: 6'd59};

    // One-second decrement with borrow from minutes; 0:00 stays at 0:00.
    function automatic time_t t_dec(time_t t);
        time_t r;
        r = t;
        if (t.sec != 6'd0) begin
            r.sec = t.sec - 6'd1;
        end else if (t.min != 4'd0) begin
            r.min = t.min - 4'd1;
            r.sec = 6'd59;
        end
        return r;
    endfunction

    // Add up to 59 s with carry into minutes; anything past 15:59 clamps there.
    function automatic time_t t_add_sat(time_t t, logic [5:0] inc);
        logic [6:0] s;
        logic [4:0] m;
        time_t      r;
        s = {1'b0, t.sec} + {1'b0, inc};
        m = {1'b0, t.min};
        if (s >= 7'd60) begin
            s = s - 7'd60;
            m = m + 5'd1;
        end
        if (m > 5'd15) begin
            r = T_MAX;
        end else begin
            r.min = m[3:0];
            r.sec = s[5:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/chess_clock_controller_tick_prescaler.sv
// Free-running 0..CLK_HZ-1 counter producing a one-cycle tick at terminal count.
// Holds while disabled; clear takes priority over enable.
module tick_prescaler #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TC) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/chess_clock_controller.sv
// Two-sided chess clock sequencer: decides whose clock runs, applies
// move presses with Fischer increment, pause, and flag-fall.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | both clocks loaded with initial time, waiting for start
// S_RUN_W  | white to move, white clock counting down
// S_RUN_B  | black to move, black clock counting down
// S_PAUSED | both clocks held; turn_w remembers whose clock resumes
// S_FLAG   | a clock reached 0:00; frozen until start
module chess_clock_controller
    import chess_clock_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int INIT_MIN = 5,
    parameter int INIT_SEC = 0,
    parameter int INC_SEC  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       press_w,
    input  logic       press_b,
    output logic [9:0] countdownW,
    output logic [9:0] countdownB,
    output logic       turn_w,
    output logic       running,
    output logic       flag_w,
    output logic       flag_b
);

    localparam time_t      T_INIT = '{min: 4'(INIT_MIN), sec: 6'(INIT_SEC)};
    localparam logic [5:0] INC    = 6'(INC_SEC);

    state_t state;
    time_t  time_w, time_b;
    time_t  dec_w, dec_b;
    logic   in_run, active_press, tick;
    logic   pre_en, pre_clr;

    assign in_run       = (state == S_RUN_W) || (state == S_RUN_B);
    assign active_press = ((state == S_RUN_W) && press_w) || ((state == S_RUN_B) && press_b);
    assign dec_w        = t_dec(time_w);
    assign dec_b        = t_dec(time_b);

    // The pause edge itself must not advance the prescaler, so the
    // fraction of the second already elapsed is preserved across a pause.
    assign pre_en  = in_run && !pause;
    assign pre_clr = (state == S_IDLE) || (state == S_FLAG)
                   || (in_run && !pause && active_press)
                   || ((state == S_PAUSED) && start);

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    assign countdownW = time_w;
    assign countdownB = time_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            time_w  <= T_INIT;
            time_b  <= T_INIT;
            turn_w  <= 1'b1;
            running <= 1'b0;
            flag_w  <= 1'b0;
            flag_b  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (T_INIT == '0) begin
                            state  <= S_FLAG;
                            flag_w <= 1'b1;
                        end else begin
                            state   <= S_RUN_W;
                            running <= 1'b1;
                        end
                    end
                end
                S_RUN_W: begin
                    if (pause) begin
                        state   <= S_PAUSED;
                        running <= 1'b0;
                    end else if (press_w) begin
                        time_w <= t_add_sat(time_w, INC);
                        state  <= S_RUN_B;
                        turn_w <= 1'b0;
                    end else if (tick) begin
                        time_w <= dec_w;
                        if (dec_w == '0) begin
                            state   <= S_FLAG;
                            flag_w  <= 1'b1;
                            running <= 1'b0;
                        end
                    end
                end
                S_RUN_B: begin
                    if (pause) begin
                        state   <= S_PAUSED;
                        running <= 1'b0;
                    end else if (press_b) begin
                        time_b <= t_add_sat(time_b, INC);
                        state  <= S_RUN_W;
                        turn_w <= 1'b1;
                    end else if (tick) begin
                        time_b <= dec_b;
                        if (dec_b == '0) begin
                            state   <= S_FLAG;
                            flag_b  <= 1'b1;
                            running <= 1'b0;
                        end
                    end
                end
                S_PAUSED: begin
                    if (start) begin
                        state   <= S_IDLE;
                        time_w  <= T_INIT;
                        time_b  <= T_INIT;
                        turn_w  <= 1'b1;
                        running <= 1'b0;
                        flag_w  <= 1'b0;
                        flag_b  <= 1'b0;
                    end else if (pause) begin
                        state   <= turn_w ? S_RUN_W : S_RUN_B;
                        running <= 1'b1;
                    end
                end
                S_FLAG: begin
                    if (start) begin
                        state   <= S_IDLE;
                        time_w  <= T_INIT;
                        time_b  <= T_INIT;
                        turn_w  <= 1'b1;
                        running <= 1'b0;
                        flag_w  <= 1'b0;
                        flag_b  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chess_clock_controller.sv
// Directed bench for chess_clock_controller with a 10-cycle second.
// Main instance uses a vector table; extra instances cover saturation, flag-fall and 0:00 init.
module tb_chess_clock_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, pause = 1'b0, press_w = 1'b0, press_b = 1'b0;
    logic sat_pw = 1'b0;
    logic low_pw = 1'b0, low_pb = 1'b0, low_pause = 1'b0;

    logic [9:0] w_m, b_m, w_s, b_s, w_l, b_l, w_z, b_z;
    logic t_m, r_m, fw_m, fb_m;
    logic t_s, r_s, fw_s, fb_s;
    logic t_l, r_l, fw_l, fb_l;
    logic t_z, r_z, fw_z, fb_z;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    chess_clock_controller #(.CLK_HZ(10), .INIT_MIN(5), .INIT_SEC(0), .INC_SEC(2)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .press_w(press_w), .press_b(press_b),
        .countdownW(w_m), .countdownB(b_m), .turn_w(t_m), .running(r_m), .flag_w(fw_m), .flag_b(fb_m));

    chess_clock_controller #(.CLK_HZ(10), .INIT_MIN(15), .INIT_SEC(58), .INC_SEC(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .press_w(sat_pw), .press_b(press_b),
        .countdownW(w_s), .countdownB(b_s), .turn_w(t_s), .running(r_s), .flag_w(fw_s), .flag_b(fb_s));

    chess_clock_controller #(.CLK_HZ(10), .INIT_MIN(1), .INIT_SEC(0), .INC_SEC(0)) dut_low (
        .clk(clk), .rst(rst), .start(start), .pause(low_pause), .press_w(low_pw), .press_b(low_pb),
        .countdownW(w_l), .countdownB(b_l), .turn_w(t_l), .running(r_l), .flag_w(fw_l), .flag_b(fb_l));

    chess_clock_controller #(.CLK_HZ(10), .INIT_MIN(0), .INIT_SEC(0), .INC_SEC(0)) dut_zero (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .press_w(1'b0), .press_b(1'b0),
        .countdownW(w_z), .countdownB(b_z), .turn_w(t_z), .running(r_z), .flag_w(fw_z), .flag_b(fb_z));

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_main(input int idx, input logic [9:0] ew, input logic [9:0] eb,
                              input logic et, input logic er, input logic efw, input logic efb);
        check("main_w", idx, 32'(w_m), 32'(ew));
        check("main_b", idx, 32'(b_m), 32'(eb));
        check("main_turn", idx, 32'(t_m), 32'(et));
        check("main_run", idx, 32'(r_m), 32'(er));
        check("main_flag_w", idx, 32'(fw_m), 32'(efw));
        check("main_flag_b", idx, 32'(fb_m), 32'(efb));
    endtask

    typedef struct {
        logic       st, pa, pw, pb;
        int         n;
        logic [9:0] ew, eb;
        logic       et, er;
    } vec_t;

    vec_t v[24];

    initial begin
        // {start, pause, press_w, press_b, edges (first carries the inputs), W, B, turn_w, running}
        v[0]  = '{1'b0, 1'b0, 1'b1, 1'b0,   1, 10'd320, 10'd320, 1'b1, 1'b0};
        v[1]  = '{1'b0, 1'b1, 1'b0, 1'b1,   1, 10'd320, 10'd320, 1'b1, 1'b0};
        v[2]  = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 10'd320, 10'd320, 1'b1, 1'b1};
        v[3]  = '{1'b0, 1'b0, 1'b0, 1'b0,   9, 10'd320, 10'd320, 1'b1, 1'b1};
        v[4]  = '{1'b0, 1'b0, 1'b0, 1'b0,   1, 10'd315, 10'd320, 1'b1, 1'b1};
        v[5]  = '{1'b0, 1'b0, 1'b0, 1'b0,   9, 10'd315, 10'd320, 1'b1, 1'b1};
        v[6]  = '{1'b0, 1'b0, 1'b1, 1'b0,   1, 10'd321, 10'd320, 1'b0, 1'b1};
        v[7]  = '{1'b0, 1'b0, 1'b1, 1'b0,   1, 10'd321, 10'd320, 1'b0, 1'b1};
        v[8]  = '{1'b0, 1'b0, 1'b0, 1'b0,   9, 10'd321, 10'd315, 1'b0, 1'b1};
        v[9]  = '{1'b0, 1'b0, 1'b1, 1'b1,   1, 10'd321, 10'd321, 1'b1, 1'b1};
        v[10] = '{1'b0, 1'b0, 1'b0, 1'b0,  10, 10'd320, 10'd321, 1'b1, 1'b1};
        v[11] = '{1'b0, 1'b0, 1'b0, 1'b0,   6, 10'd320, 10'd321, 1'b1, 1'b1};
        v[12] = '{1'b0, 1'b1, 1'b1, 1'b0,   1, 10'd320, 10'd321, 1'b1, 1'b0};
        v[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 100, 10'd320, 10'd321, 1'b1, 1'b0};
        v[14] = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 10'd320, 10'd321, 1'b1, 1'b1};
        v[15] = '{1'b0, 1'b0, 1'b0, 1'b0,   3, 10'd320, 10'd321, 1'b1, 1'b1};
        v[16] = '{1'b0, 1'b0, 1'b0, 1'b0,   1, 10'd315, 10'd321, 1'b1, 1'b1};
        v[17] = '{1'b0, 1'b0, 1'b1, 1'b0,   1, 10'd321, 10'd321, 1'b0, 1'b1};
        v[18] = '{1'b0, 1'b1, 1'b0, 1'b0,   1, 10'd321, 10'd321, 1'b0, 1'b0};
        v[19] = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 10'd320, 10'd320, 1'b1, 1'b0};
        v[20] = '{1'b1, 1'b0, 1'b0, 1'b0,   1, 10'd320, 10'd320, 1'b1, 1'b1};
        v[21] = '{1'b1, 1'b0, 1'b0, 1'b0,   5, 10'd320, 10'd320, 1'b1, 1'b1};
        v[22] = '{1'b0, 1'b0, 1'b0, 1'b0,   5, 10'd315, 10'd320, 1'b1, 1'b1};
        v[23] = '{1'b0, 1'b0, 1'b1, 1'b0,   1, 10'd321, 10'd320, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_main(-1, 10'd320, 10'd320, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            start = v[i].st; pause = v[i].pa; press_w = v[i].pw; press_b = v[i].pb;
            @(negedge clk);
            start = 1'b0; pause = 1'b0; press_w = 1'b0; press_b = 1'b0;
            repeat (v[i].n - 1) @(negedge clk);
            check_main(i, v[i].ew, v[i].eb, v[i].et, v[i].er, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a cycle while black runs.
        #2 rst = 1'b1;
        #1 check_main(100, 10'd320, 10'd320, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("zero_rst_w", 0, 32'(w_z), 32'd0);
        check("sat_rst_w", 0, 32'(w_s), 32'd1018);
        check("low_rst_w", 0, 32'(w_l), 32'd64);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_flag_w", 0, 32'(fw_z), 32'd1);
        check("zero_run", 0, 32'(r_z), 32'd0);
        check("zero_flag_b", 0, 32'(fb_z), 32'd0);
        check("low_run", 0, 32'(r_l), 32'd1);

        sat_pw = 1'b1;
        @(negedge clk);
        sat_pw = 1'b0;
        check("sat_w", 0, 32'(w_s), 32'd1019);
        check("sat_turn", 0, 32'(t_s), 32'd0);
        check("sat_b", 0, 32'(b_s), 32'd1018);

        repeat (8) @(negedge clk);
        check("low_w", 0, 32'(w_l), 32'd64);
        @(negedge clk);
        check("low_w", 1, 32'(w_l), 32'd59);
        repeat (580) @(negedge clk);
        check("low_w", 2, 32'(w_l), 32'd1);
        repeat (9) @(negedge clk);
        check("low_w", 3, 32'(w_l), 32'd1);
        check("low_flag_w", 0, 32'(fw_l), 32'd0);
        @(negedge clk);
        check("low_w", 4, 32'(w_l), 32'd0);
        check("low_flag_w", 1, 32'(fw_l), 32'd1);
        check("low_run", 1, 32'(r_l), 32'd0);
        check("low_b", 0, 32'(b_l), 32'd64);

        low_pw = 1'b1;    @(negedge clk); low_pw = 1'b0;
        low_pb = 1'b1;    @(negedge clk); low_pb = 1'b0;
        low_pause = 1'b1; @(negedge clk); low_pause = 1'b0;
        repeat (47) @(negedge clk);
        check("low_w", 5, 32'(w_l), 32'd0);
        check("low_b", 1, 32'(b_l), 32'd64);
        check("low_flag_w", 2, 32'(fw_l), 32'd1);
        check("low_flag_b", 0, 32'(fb_l), 32'd0);
        check("low_run", 2, 32'(r_l), 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("low_w", 6, 32'(w_l), 32'd64);
        check("low_b", 2, 32'(b_l), 32'd64);
        check("low_flag_w", 3, 32'(fw_l), 32'd0);
        check("low_turn", 0, 32'(t_l), 32'd1);
        check("low_run", 3, 32'(r_l), 32'd0);
        check("zero_flag_w", 1, 32'(fw_z), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
